mem_port_arbiter: RTL and testbench

//  Shares one single-ported synchronous instruction/data memory between the IF stage
//  (fetch port) and the MEM stage (data port) of the 8-bit pipelined core.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_port_arbiter_lat_counter.sv | 28 ++
 rtl/mem_port_arbiter.sv | 115 +++++++++++
 tb/tb_mem_port_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths and state/owner encodings for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, data port and memory-side bus of the arbiter.
// slave = arbiter side; master = the core/memory environment driving requests and read data.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_kill;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall_out;

    modport slave (
        input  if_req, if_addr, if_kill,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output stall_out
    );

    modport master (
        output if_req, if_addr, if_kill,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  stall_out
    );

endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// Read-latency timer: loaded on each read issue, o_done marks the cycle read data is valid
// (MEM_LAT cycles after load); no backpressure, a new load always overrides the running count.
module mem_lat_counter #(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    output logic o_done
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(MEM_LAT);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data ports; grants are combinational,
// read data returns MEM_LAT cycles after grant, and a losing/blocked requester sees stall_out.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    owner_t            r_owner;
    logic              r_kill;
    logic [SW-1:0]     r_starve;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_done;
    logic              w_ready;
    logic              w_fetch_first;
    logic              w_if_gnt;
    logic              w_d_gnt;
    logic              w_rd_issue;

    mem_lat_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_lat (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_rd_issue),
        .o_done (w_done)
    );

    // The rvalid cycle of a pending read doubles as an issue slot (back-to-back reads).
    assign w_ready       = !reset && ((r_state == IDLE) || w_done);
    assign w_fetch_first = bus.if_req && (r_starve == SW'(STARVE_MAX));
    assign w_rd_issue    = w_if_gnt || (w_d_gnt && !bus.d_we);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_if_gnt    = 1'b0;
        w_d_gnt     = 1'b0;
        w_state_nxt = r_state;
        if (w_ready) begin
            if (bus.if_req && (w_fetch_first || !bus.d_req)) begin
                w_if_gnt = 1'b1;
            end else if (bus.d_req) begin
                w_d_gnt = 1'b1;
            end
            w_state_nxt = ((w_if_gnt || (w_d_gnt && !bus.d_we)) && (MEM_LAT > 1)) ? RD_WAIT : IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner  <= OWN_NONE;
            r_kill   <= 1'b0;
            r_starve <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            if (w_rd_issue) begin
                r_owner <= w_if_gnt ? OWN_IF : OWN_D;
                r_kill  <= w_if_gnt && bus.if_kill;
            end else if (w_done) begin
                r_owner <= OWN_NONE;
                r_kill  <= 1'b0;
            end else if (bus.if_kill) begin
                r_kill  <= 1'b1;
            end

            if (!bus.if_req || w_if_gnt) begin
                r_starve <= '0;
            end else if (w_d_gnt && (r_starve != SW'(STARVE_MAX))) begin
                r_starve <= r_starve + SW'(1);
            end

            if (w_if_gnt || w_d_gnt) begin
                r_addr <= bus.mem_addr;
            end
            if (w_d_gnt) begin
                r_wdata <= bus.d_wdata;
            end
        end
    end

    assign bus.if_gnt    = w_if_gnt;
    assign bus.d_gnt     = w_d_gnt;
    assign bus.mem_en    = w_if_gnt || w_d_gnt;
    assign bus.mem_we    = w_d_gnt && bus.d_we;
    assign bus.mem_addr  = w_if_gnt ? bus.if_addr : (w_d_gnt ? bus.d_addr : r_addr);
    assign bus.mem_wdata = w_d_gnt ? bus.d_wdata : r_wdata;

    // A kill arriving in the data-return cycle itself still suppresses the fetch.
    assign bus.if_rvalid = w_done && (r_owner == OWN_IF) && !r_kill && !bus.if_kill;
    assign bus.d_rvalid  = w_done && (r_owner == OWN_D);
    assign bus.if_rdata  = reset ? '0 : bus.mem_rdata;
    assign bus.d_rdata   = reset ? '0 : bus.mem_rdata;

    assign bus.stall_out = !reset && ((bus.if_req && !w_if_gnt) || (bus.d_req && !w_d_gnt));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Three arbiters (MEM_LAT 1..3) driven side by side; a cycle-level reference model predicts
// grants and read returns, and a monitor on the falling edge pops and compares them.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int NL   = 3;
    localparam int SMAX = 3;
    localparam int G_NONE = 0;
    localparam int G_IF   = 1;
    localparam int G_D    = 2;

    typedef struct {
        bit                vld;
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } rsp_t;

    typedef struct {
        int                gnt;
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        bit                stall;
        bit                rst;
    } cyc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              t_if_req  [NL];
    logic              t_if_kill [NL];
    logic [ADDR_W-1:0] t_if_addr [NL];
    logic              t_d_req   [NL];
    logic              t_d_we    [NL];
    logic [ADDR_W-1:0] t_d_addr  [NL];
    logic [DATA_W-1:0] t_d_wdata [NL];

    logic [NL-1:0]     o_if_gnt, o_if_rvalid, o_d_gnt, o_d_rvalid, o_mem_en, o_mem_we, o_stall;
    logic [DATA_W-1:0] o_if_rdata  [NL];
    logic [DATA_W-1:0] o_d_rdata   [NL];
    logic [ADDR_W-1:0] o_mem_addr  [NL];
    logic [DATA_W-1:0] o_mem_wdata [NL];

    function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
        return {a ^ 8'hA5, ~a};
    endfunction

    for (genvar g = 0; g < NL; g++) begin : lane
        mem_port_arbiter_if bus ();
        bit [DATA_W-1:0] mem  [256];
        bit [255:0]      written;
        bit [DATA_W-1:0] pipe [4];

        assign bus.if_req    = t_if_req[g];
        assign bus.if_addr   = t_if_addr[g];
        assign bus.if_kill   = t_if_kill[g];
        assign bus.d_req     = t_d_req[g];
        assign bus.d_we      = t_d_we[g];
        assign bus.d_addr    = t_d_addr[g];
        assign bus.d_wdata   = t_d_wdata[g];
        assign bus.mem_rdata = pipe[g];

        assign o_if_gnt[g]    = bus.if_gnt;
        assign o_if_rvalid[g] = bus.if_rvalid;
        assign o_if_rdata[g]  = bus.if_rdata;
        assign o_d_gnt[g]     = bus.d_gnt;
        assign o_d_rvalid[g]  = bus.d_rvalid;
        assign o_d_rdata[g]   = bus.d_rdata;
        assign o_mem_en[g]    = bus.mem_en;
        assign o_mem_we[g]    = bus.mem_we;
        assign o_mem_addr[g]  = bus.mem_addr;
        assign o_mem_wdata[g] = bus.mem_wdata;
        assign o_stall[g]     = bus.stall_out;

        // Synchronous memory: read data appears MEM_LAT cycles after the issue cycle.
        always @(posedge clk) begin
            if (bus.mem_en && bus.mem_we) begin
                mem[bus.mem_addr]     <= bus.mem_wdata;
                written[bus.mem_addr] <= 1'b1;
            end
            if (bus.mem_en && !bus.mem_we) begin
                pipe[0] <= written[bus.mem_addr] ? mem[bus.mem_addr] : init_word(bus.mem_addr);
            end else begin
                pipe[0] <= 16'hDEAD;
            end
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end

        mem_port_arbiter #(
            .MEM_LAT    (g + 1),
            .STARVE_MAX (SMAX)
        ) u_dut (
            .clk   (clk),
            .reset (rst),
            .bus   (bus)
        );
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    function automatic void chkb(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %b expected %b", nm, cyc, act, exp);
        end
    endfunction

    function automatic void chkw(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%h expected 0x%h", nm, cyc, act, exp);
        end
    endfunction

    function automatic int lat(input int l);
        return l + 1;
    endfunction

    // Reference model state: issue slots by cycle number, not by FSM state.
    logic [DATA_W-1:0] shadow [NL][256];
    int                free_at   [NL];
    int                starve    [NL];
    int                last_gnt  [NL];
    logic [ADDR_W-1:0] last_addr [NL];
    logic [DATA_W-1:0] last_wd   [NL];
    req_t              cur_if    [NL];
    req_t              cur_d     [NL];
    bit                kill_arm  [NL];
    bit                rnd_kill = 1'b0;
    req_t              fq    [NL][$];
    req_t              dq    [NL][$];
    rsp_t              rq_if [NL][$];
    rsp_t              rq_d  [NL][$];
    cyc_t              ex_q  [NL][$];

    function automatic req_t mk(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
        req_t r;
        r.vld = 1'b1; r.we = we; r.addr = a; r.wdata = wd;
        return r;
    endfunction

    function automatic req_t bubble();
        req_t r;
        r.vld = 1'b0; r.we = 1'b0; r.addr = '0; r.wdata = '0;
        return r;
    endfunction

    function automatic req_t rand_req(input bit is_d);
        req_t r;
        r.vld   = ($urandom_range(0, 2) != 0);
        r.we    = is_d && ($urandom_range(0, 2) == 0);
        r.addr  = 8'($urandom_range(0, 15));
        r.wdata = 16'($urandom);
        return r;
    endfunction

    task automatic step(input bit r);
        @(posedge clk);
        cyc++;
        #1;
        rst = r;
        for (int l = 0; l < NL; l++) begin
            bit   kill;
            int   g;
            cyc_t e;
            if (!cur_if[l].vld || last_gnt[l] == G_IF)
                cur_if[l] = (fq[l].size() > 0) ? fq[l].pop_front() : bubble();
            if (!cur_d[l].vld || last_gnt[l] == G_D)
                cur_d[l] = (dq[l].size() > 0) ? dq[l].pop_front() : bubble();
            kill = 1'b0;
            if (kill_arm[l] && last_gnt[l] == G_IF) begin
                kill = 1'b1;
                kill_arm[l] = 1'b0;
            end
            if (rnd_kill && $urandom_range(0, 11) == 0) kill = 1'b1;

            t_if_req[l]  = cur_if[l].vld;
            t_if_addr[l] = cur_if[l].addr;
            t_if_kill[l] = kill;
            t_d_req[l]   = cur_d[l].vld;
            t_d_we[l]    = cur_d[l].vld && cur_d[l].we;
            t_d_addr[l]  = cur_d[l].addr;
            t_d_wdata[l] = cur_d[l].wdata;

            g = G_NONE;
            if (!r && cyc >= free_at[l]) begin
                if (cur_if[l].vld && (!cur_d[l].vld || starve[l] == SMAX)) g = G_IF;
                else if (cur_d[l].vld) g = G_D;
            end
            if (kill) rq_if[l].delete();

            e = '{gnt: G_NONE, we: 1'b0, addr: '0, wdata: '0, stall: 1'b0, rst: r};
            if (r) begin
                rq_if[l].delete();
                rq_d[l].delete();
                free_at[l]   = 0;
                starve[l]    = 0;
                last_addr[l] = '0;
                last_wd[l]   = '0;
            end else begin
                e.stall = (cur_if[l].vld && g != G_IF) || (cur_d[l].vld && g != G_D);
                if (g == G_IF) begin
                    if (!kill) rq_if[l].push_back('{due: cyc + lat(l), data: shadow[l][cur_if[l].addr]});
                    free_at[l]   = cyc + lat(l);
                    last_addr[l] = cur_if[l].addr;
                end else if (g == G_D) begin
                    if (cur_d[l].we) begin
                        shadow[l][cur_d[l].addr] = cur_d[l].wdata;
                        free_at[l] = cyc + 1;
                    end else begin
                        rq_d[l].push_back('{due: cyc + lat(l), data: shadow[l][cur_d[l].addr]});
                        free_at[l] = cyc + lat(l);
                    end
                    last_addr[l] = cur_d[l].addr;
                    last_wd[l]   = cur_d[l].wdata;
                end
                if (!cur_if[l].vld || g == G_IF) starve[l] = 0;
                else if (g == G_D && starve[l] < SMAX) starve[l]++;
                e.gnt   = g;
                e.we    = (g == G_D) && cur_d[l].we;
                e.addr  = last_addr[l];
                e.wdata = last_wd[l];
            end
            ex_q[l].push_back(e);
            last_gnt[l] = g;
        end
    endtask

    task automatic run_until_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 300 && !idle; i++) begin
            step(1'b0);
            @(negedge clk);
            #1;
            idle = 1'b1;
            for (int l = 0; l < NL; l++) begin
                if (fq[l].size() != 0 || dq[l].size() != 0 || cur_if[l].vld || cur_d[l].vld ||
                    rq_if[l].size() != 0 || rq_d[l].size() != 0)
                    idle = 1'b0;
            end
        end
        chkb("drain_done", idle, 1'b1);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            for (int l = 0; l < NL; l++) begin
                cyc_t e;
                bit   ev;
                if (ex_q[l].size() == 0) continue;
                e = ex_q[l].pop_front();
                chkb($sformatf("L%0d if_gnt", l), o_if_gnt[l], e.gnt == G_IF);
                chkb($sformatf("L%0d d_gnt", l), o_d_gnt[l], e.gnt == G_D);
                chkb($sformatf("L%0d mem_en", l), o_mem_en[l], e.gnt != G_NONE);
                chkb($sformatf("L%0d mem_we", l), o_mem_we[l], e.we);
                chkb($sformatf("L%0d stall", l), o_stall[l], e.stall);
                chkw($sformatf("L%0d mem_addr", l), 16'(o_mem_addr[l]), 16'(e.addr));
                if (e.we || e.rst)
                    chkw($sformatf("L%0d mem_wdata", l), o_mem_wdata[l], e.wdata);
                if (e.rst) begin
                    chkw($sformatf("L%0d rst if_rdata", l), o_if_rdata[l], 16'h0);
                    chkw($sformatf("L%0d rst d_rdata", l), o_d_rdata[l], 16'h0);
                end
                ev = (rq_if[l].size() > 0) && (rq_if[l][0].due == cyc);
                chkb($sformatf("L%0d if_rvalid", l), o_if_rvalid[l], ev);
                if (ev) begin
                    chkw($sformatf("L%0d if_rdata", l), o_if_rdata[l], rq_if[l][0].data);
                    void'(rq_if[l].pop_front());
                end
                ev = (rq_d[l].size() > 0) && (rq_d[l][0].due == cyc);
                chkb($sformatf("L%0d d_rvalid", l), o_d_rvalid[l], ev);
                if (ev) begin
                    chkw($sformatf("L%0d d_rdata", l), o_d_rdata[l], rq_d[l][0].data);
                    void'(rq_d[l].pop_front());
                end
            end
        end
    end

    initial begin : stim
        for (int l = 0; l < NL; l++) begin
            for (int a = 0; a < 256; a++) shadow[l][a] = init_word(8'(a));
            free_at[l] = 0; starve[l] = 0; last_gnt[l] = G_NONE;
            last_addr[l] = '0; last_wd[l] = '0; kill_arm[l] = 1'b0;
            cur_if[l] = bubble(); cur_d[l] = bubble();
            t_if_req[l] = 1'b0; t_if_addr[l] = '0; t_if_kill[l] = 1'b0;
            t_d_req[l] = 1'b0; t_d_we[l] = 1'b0; t_d_addr[l] = '0; t_d_wdata[l] = '0;
        end
        repeat (3) step(1'b1);

        // Fetch-only stream 0x00..0x03.
        for (int l = 0; l < NL; l++)
            for (int a = 0; a < 4; a++) fq[l].push_back(mk(1'b0, 8'(a), 16'h0));
        run_until_idle();

        // Fetch and data read requested together: data first.
        for (int l = 0; l < NL; l++) begin
            fq[l].push_back(mk(1'b0, 8'h20, 16'h0));
            dq[l].push_back(mk(1'b0, 8'h40, 16'h0));
        end
        run_until_idle();

        // Continuous data reads against a waiting fetch: starvation relief.
        for (int l = 0; l < NL; l++) begin
            for (int a = 0; a < 6; a++) dq[l].push_back(mk(1'b0, 8'(8'h40 + a), 16'h0));
            fq[l].push_back(mk(1'b0, 8'h30, 16'h0));
            fq[l].push_back(mk(1'b0, 8'h31, 16'h0));
        end
        run_until_idle();

        // Write then read back.
        for (int l = 0; l < NL; l++) begin
            dq[l].push_back(mk(1'b1, 8'h10, 16'hBEEF));
            dq[l].push_back(mk(1'b0, 8'h10, 16'h0));
        end
        run_until_idle();

        // Fetch killed the cycle after its grant; a data read waits out the latency.
        for (int l = 0; l < NL; l++) begin
            kill_arm[l] = 1'b1;
            fq[l].push_back(mk(1'b0, 8'h05, 16'h0));
            dq[l].push_back(bubble());
            dq[l].push_back(mk(1'b0, 8'h06, 16'h0));
        end
        run_until_idle();

        // Reset while a fetch read is in flight.
        for (int l = 0; l < NL; l++) fq[l].push_back(mk(1'b0, 8'h07, 16'h0));
        step(1'b0);
        step(1'b1);
        step(1'b1);
        run_until_idle();

        // Randomised contention with writes and kills.
        rnd_kill = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            for (int l = 0; l < NL; l++) begin
                if (fq[l].size() < 2) fq[l].push_back(rand_req(1'b0));
                if (dq[l].size() < 2) dq[l].push_back(rand_req(1'b1));
            end
            step(1'b0);
        end
        rnd_kill = 1'b0;
        run_until_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
